// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared FSM encoding, default parameters and clog2 helper for tri_bus_arb.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none. Build option TRI_BUS_KEEPER_EN is consumed by tri_bus_arb, not here.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_MAX_HOLD   = 16;

  // ceil(log2(n)); clog2(1) = 0, callers floor widths at 1 where needed.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req at or after ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; losing requests are simply not selected.
// Ports: req_i[N], ptr_i (search start) -> win_oh_o (one-hot or zero), win_idx_o, win_vld_o.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          win_vld_o
);

  localparam int SW = IW + 1;

  logic [SW-1:0] pos;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i + k folded back into 0..N-1 without a divider.
      pos = {1'b0, ptr_i} + SW'(k);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      if (!win_vld_o && req_i[pos[IW-1:0]]) begin
        win_vld_o               = 1'b1;
        win_oh_o[pos[IW-1:0]]   = 1'b1;
        win_idx_o               = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/tri_bus_arb.sv
// tri_bus_arb: N-channel shared tri-state bus driver with registered round-robin ownership.
// Latency: req sampled at edge k -> grant/bus driven after edge k; TURNAROUND Z cycles between owners.
// Backpressure: losing reqs stay pending (level); owner preempted after MAX_HOLD cycles if others wait.
// Ports: clk, rst_n (async active-low), req[NUM_CH], din[NUM_CH*WIDTH]
//        -> grant (one-hot), owner, bus_valid, bus (inout, Z unless driving), bus_rd (registered sample).
// Build option: define TRI_BUS_KEEPER_EN so bus_rd holds the last driven value instead of loading 0.
module tri_bus_arb
  import tri_bus_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*WIDTH-1:0]   din,
  output logic [NUM_CH-1:0]         grant,
  output logic [clog2(NUM_CH)-1:0]  owner,
  output logic                      bus_valid,
  inout  wire  [WIDTH-1:0]          bus,
  output logic [WIDTH-1:0]          bus_rd
);

  localparam int IW = clog2(NUM_CH);
  localparam int HW = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
  localparam int TW = (TURNAROUND > 1) ? clog2(TURNAROUND) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              oe_q, oe_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [WIDTH-1:0]  bus_rd_q, bus_rd_d;

  logic [NUM_CH-1:0] win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic              arb_go;
  logic              other_req;
  logic [WIDTH-1:0]  drv_dat;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_rr (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld)
  );

  // grant_q is one-hot on the owner in DRIVE, so this is "anyone else waiting".
  assign other_req = |(req & ~grant_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    oe_d     = oe_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    arb_go   = 1'b0;

    unique case (state_q)
      IDLE: arb_go = win_vld;
      DRIVE: begin
        if (!req[owner_q] || (hold_q == HOLD_LAST && other_req)) begin
          state_d = TURN;
          grant_d = '0;
          oe_d    = 1'b0;
          turn_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        // Last Z cycle doubles as the arbitration cycle, so a waiting
        // channel drives right after TURNAROUND cycles, never earlier.
        if (turn_q == TURN_LAST) begin
          if (win_vld) arb_go  = 1'b1;
          else         state_d = IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_go) begin
      state_d  = DRIVE;
      grant_d  = win_oh;
      owner_d  = win_idx;
      oe_d     = 1'b1;
      rr_ptr_d = (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
      hold_d   = '0;
    end
  end

  // Data is combinational from the owner's channel; only the enable is registered.
  assign drv_dat = din[owner_q*WIDTH +: WIDTH];
  assign bus     = oe_q ? drv_dat : {WIDTH{1'bz}};

  // drv_dat equals the bus pin whenever oe_q is set, and avoids reading back a Z net.
`ifdef TRI_BUS_KEEPER_EN
  assign bus_rd_d = oe_q ? drv_dat : bus_rd_q;
`else
  assign bus_rd_d = oe_q ? drv_dat : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      oe_q     <= 1'b0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      bus_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      oe_q     <= oe_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      bus_rd_q <= bus_rd_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_valid = oe_q;
  assign bus_rd    = bus_rd_q;

endmodule

// File: doc/tri_bus_arb.md
# tri_bus_arb

Parametrised shared tri-state bus driver with registered round-robin arbitration. Up to NUM_CH local sources contend for one WIDTH-bit tri-state bus; exactly one source drives it at a time. Enforced turnaround cycles keep two drivers from overlapping. Sits between the channel muxes and the shared board/chip bus, generalising the single 2:1 tri-state mux to N channels with ownership, fairness and hold limits.

## Interface
- WIDTH, 8, bus data width (≥1)
- NUM_CH, 4, number of requesting channels (2..16)
- TURNAROUND, 1, idle Z cycles between owners (≥1)
- MAX_HOLD, 16, max consecutive DRIVE cycles while another channel waits (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_CH  per-channel bus request, level-sensitive
- din  in  NUM_CH*WIDTH  channel data, channel i at [i*WIDTH +: WIDTH]
- grant  out  NUM_CH  one-hot owner, registered
- owner  out  clog2(NUM_CH)  index of current owner, valid when bus_valid
- bus_valid  out  1  bus currently driven by this block
- bus  inout  WIDTH  shared bus; driven only in DRIVE, else all Z
- bus_rd  out  WIDTH  registered sample of bus (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, TURN.
- IDLE:
  - If any req is set, pick the winner round-robin starting at rr_ptr, load grant/owner, go to DRIVE.
  - If no req is set, stay in IDLE.
- DRIVE:
  - bus = din[owner]; bus_valid=1.
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Leave to TURN when req[owner]=0.
  - Also leave to TURN when hold_cnt==MAX_HOLD-1 and any other req is set (preemption).
  - If the owner is alone, it keeps the bus indefinitely.
- TURN:
  - grant=0, bus_valid=0, bus=Z.
  - Count TURNAROUND cycles, then go to IDLE.
  - In the last TURN cycle, arbitrate as in IDLE and go straight to DRIVE if any req is set.
- rr_ptr updates to (owner+1) mod NUM_CH on every entry to DRIVE.
- hold_cnt clears on entry to DRIVE.
- Output enable is a single registered signal. Data path is combinational from din[owner] while enabled, so din changes during DRIVE appear on bus the same cycle.
- req from a channel that loses arbitration persists; it is never dropped or latched.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, grant=0, owner=0, bus_valid=0, bus=Z, bus_rd=0, rr_ptr=0, hold_cnt=0.
- Grant latency: req sampled high at edge k in IDLE → grant, bus_valid, bus driven after edge k.
- Release: req[owner] sampled low at edge m → grant=0 and bus=Z after edge m.
- Next owner drives after edge m+TURNAROUND at the earliest.
- Bus is never driven by two grant bits in one cycle; grant is always one-hot or zero.
- Simultaneous release and new request: the turnaround is still enforced, even when the new requester is the same channel.
- Preemption: with two channels continuously requesting, each holds exactly MAX_HOLD cycles, followed by TURNAROUND Z cycles.
- rr_ptr wrap-around: NUM_CH-1 → 0.
- req changes mid-TURN are ignored until the arbitration cycle.
- Reset mid-DRIVE: bus goes Z immediately (async), no turnaround.
- bus_rd latency: one cycle after bus.

## Configuration
- Macro: TRI_BUS_KEEPER_EN.
- Defined:
  - bus_rd loads bus only when bus_valid=1.
  - Otherwise bus_rd holds the last driven value (bus keeper), through TURN/IDLE and across owners.
- Undefined:
  - bus_rd loads bus when bus_valid=1.
  - bus_rd loads 0 when bus_valid=0, so no X/Z ever reaches bus_rd.
- The bus pin behaviour is identical in both builds.

## Structure
- Shared include tri_bus_pkg holds:
  - FSM state encodings (IDLE=2'd0, DRIVE=2'd1, TURN=2'd2).
  - The clog2 function.
  - Default parameter constants.
- One sub-module: rr_arbiter.
  - Combinational round-robin pick of req from rr_ptr.
  - Outputs a one-hot winner and its index.
- Top level holds the FSM, counters, tri-state driver and bus_rd register.

## Test plan
- Reset then req=4'b0100, din[2]=8'hA5 → grant=4'b0100 after next edge, bus=8'hA5, owner=2; bus=Z throughout reset.
- req=4'b1111 held, MAX_HOLD=4, TURNAROUND=1 → owners 0,1,2,3,0 in order, each 4 cycles DRIVE + 1 cycle Z; never two grant bits.
- Owner 1 drops req while req[3]=1 → exactly TURNAROUND Z cycles, then bus=din[3]; rr_ptr → 0 after grant to 3.
- Single requester req=4'b0001 for 40 cycles → no preemption, bus=din[0] continuous, hold_cnt saturates.
- rst_n low mid-DRIVE → bus=Z and grant=0 without waiting for clk; after release, arbitration restarts at channel 0.
- Keeper check: drive 8'h3C, release → with TRI_BUS_KEEPER_EN bus_rd stays 8'h3C; without, bus_rd=8'h00 one cycle after bus_valid falls.
